frame_reader: RTL and testbench
===============================

Name: frame_reader

Overview:
- Downstream stage of the camera capture path: scans the QVGA frame buffer that the capture block fills.
- Generates 640x480@60 video timing, issues read addresses to the buffer's read port, and pixel-doubles 320x240 to 640x480.
- Expands RGB444 to RGB888 and presents a display-ready stream (sync, data-enable, pixel) to the HDMI/VGA encoder.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- SRC_W, 320, frame buffer line length (H_ACTIVE/2)
- ADDR_W, 17, frame buffer address width
- PIX_W, 12, stored pixel width (RGB444)

Ports:
- iclk  in  1  pixel clock (25.175 MHz nominal)
- ireset  in  1  asynchronous, active-high reset
- ienable  in  1  display enable; sampled only at frame start
- oaddr  out  ADDR_W  frame buffer read address
- ord_en  out  1  frame buffer read enable
- irdata  in  PIX_W  frame buffer read data, valid the cycle after ord_en
- ohsync  out  1  horizontal sync
- ovsync  out  1  vertical sync
- ode  out  1  data enable (active video)
- opixel  out  24  RGB888 pixel, {R,G,B}
- oframe_start  out  1  one-cycle pulse aligned with the output of pixel (0,0)

Behaviour:
- Reset (async, ireset=1):
  - Counters h=0, v=0; all pipeline stages cleared.
  - Outputs: oaddr=0, ord_en=0, ode=0, opixel=0, oframe_start=0, ohsync=~HS_POL, ovsync=~VS_POL.
  - Enable latch = 0.
- Counters:
  - h runs 0..H_TOTAL-1 (H_TOTAL=800) and wraps to 0.
  - v increments when h wraps and runs 0..V_TOTAL-1 (V_TOTAL=525), wrapping to 0.
  - Counters run continuously after reset, independent of ienable.
- Timing decode at counter stage:
  - active = h<H_ACTIVE && v<V_ACTIVE.
  - hs_act for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_act for lines 490..491.
- Enable latch:
  - Loads ienable when (h,v)=(0,0); held for the whole frame.
  - Deassertion mid-frame has no effect until the next frame.
- Address generation (no multiplier):
  - Register line_base; addr = line_base + (h>>1).
  - line_base += SRC_W when h wraps on an odd active line (v[0]=1, v<V_ACTIVE).
  - line_base clears to 0 when v wraps.
  - Resulting range: 0..76799. Each source pixel is read on two consecutive cycles; each source line is read on two consecutive lines.
- Read port:
  - Stage 1: oaddr and ord_en are registered from the stage-0 counters.
  - ord_en=1 only for active && enable latch; oaddr holds its last value otherwise.
- Data return:
  - irdata is valid in stage 2.
  - Stage 3 registers opixel = expand(irdata) when de is delayed, else 24'h0.
  - Expansion: nibble replication, R8={R4,R4}, same for G and B.
  - Enable latch=0 → opixel=0 while ode still follows timing.
- Latency:
  - ohsync, ovsync, ode, oframe_start are delayed 3 cycles from the counter stage through a matched shift register.
  - All outputs therefore correspond to the same (h,v).
  - Polarity is applied at the output register.
- Reset mid-frame: outputs return to reset values immediately; after release, scanning restarts at (0,0) and the first frame is fully formed.
- Simultaneous h wrap and v wrap: the line_base clear takes priority over the increment.

Decomposition:
- Package video_pkg:
  - 640x480 timing constants and H_TOTAL/V_TOTAL.
  - typedefs rgb444_t (packed r,g,b 4-bit) and rgb888_t.
  - function rgb444_to_888.
- One sub-module: video_timing_gen.
  - Owns the h/v counters, active/hs_act/vs_act/frame_start decode.
  - Also used later by the HDMI encoder bench.
- frame_reader owns the address generator, enable latch, delay pipeline and pixel expansion.

Test Plan:
- Reset held 10 cycles → ohsync=1, ovsync=1, ode=0, opixel=0, ord_en=0. After release, the first oframe_start occurs at cycle 3, and subsequent pulses are exactly 420000 cycles apart.
- Line 0 scan → oaddr sequence 0,0,1,1,...,319,319 over h=0..639; line 1 repeats 0..319; line 2 starts at 320; line 479 ends at 76799; ord_en low at h=640..799.
- Timing check → ohsync low for exactly 96 cycles, starting 656 cycles after the start of ode on each line; ovsync low during lines 490-491; ode high for 640 cycles × 480 lines per frame.
- Buffer model returns addr-derived data, e.g. addr 5 → 12'hF80 → opixel=24'hFF8800 at output pixels (10,0), (11,0), (10,1), (11,1), in the same cycle ode is high.
- ienable 1→0 at line 200 → frame N continues with valid pixels; frame N+1 has opixel=0 and ord_en=0 with normal sync/de. ienable 0→1 mid-frame → pixels resume only at the next frame.
- ireset pulsed asynchronously mid-line at (h=300, v=100) → outputs reach reset values within the same cycle. After release, oaddr restarts at 0, and the next oframe_start arrives 3 cycles after release.

Source files
------------

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - 640x480@60 timing constants, pixel types and RGB444->RGB888 expansion
package video_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   // Timing flags carried alongside the read pipeline.
   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic fs;
   } tim_t;

   function automatic rgb888_t rgb444_to_888(input rgb444_t p);
      rgb888_t q;
      q.r = {p.r, p.r};
      q.g = {p.g, p.g};
      q.b = {p.b, p.b};
      return q;
   endfunction

endpackage

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - free-running h/v raster counters with active/sync/frame-start decode
module video_timing_gen
   import video_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
   parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
   input  logic          clk,
   input  logic          rst,
   output logic [HW-1:0] h,
   output logic [VW-1:0] v,
   output logic          active,
   output logic          hs_act,
   output logic          vs_act,
   output logic          frame_start,
   output logic          line_last,
   output logic          frame_last
);

   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
   localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
   localparam logic [HW-1:0] HA     = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] VA     = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h <= '0;
         v <= '0;
      end else if (line_last) begin
         h <= '0;
         v <= frame_last ? '0 : v + 1'b1;
      end else begin
         h <= h + 1'b1;
      end
   end

   assign line_last   = (h == H_LAST);
   assign frame_last  = (v == V_LAST);
   assign active      = (h < HA) && (v < VA);
   assign hs_act      = (h >= HS_BEG) && (h < HS_END);
   assign vs_act      = (v >= VS_BEG) && (v < VS_END);
   assign frame_start = (h == '0) && (v == '0);

endmodule

// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - scans the QVGA buffer pixel-doubled onto a 640x480 raster, RGB444->RGB888 out
module frame_reader
   import video_pkg::*;
#(
   parameter int   H_ACTIVE = VGA_H_ACTIVE,
   parameter int   H_FP     = VGA_H_FP,
   parameter int   H_SYNC   = VGA_H_SYNC,
   parameter int   H_BP     = VGA_H_BP,
   parameter int   V_ACTIVE = VGA_V_ACTIVE,
   parameter int   V_FP     = VGA_V_FP,
   parameter int   V_SYNC   = VGA_V_SYNC,
   parameter int   V_BP     = VGA_V_BP,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   SRC_W    = H_ACTIVE / 2,
   parameter int   ADDR_W   = 17,
   parameter int   PIX_W    = 12
) (
   input  logic              iclk,
   input  logic              ireset,
   input  logic              ienable,
   output logic [ADDR_W-1:0] oaddr,
   output logic              ord_en,
   input  logic [PIX_W-1:0]  irdata,
   output logic              ohsync,
   output logic              ovsync,
   output logic              ode,
   output logic [23:0]       opixel,
   output logic              oframe_start
);

   localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

   logic [HW-1:0]     h;
   logic [VW-1:0]     v;
   logic              active, hs_act, vs_act, frame_start, line_last, frame_last;
   logic              en_latch, frame_en;
   logic [ADDR_W-1:0] line_base, rd_addr;
   tim_t              s1, s2;
   logic              rd_en2;

   video_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HW(HW), .VW(VW)
   ) u_timing (
      .clk(iclk), .rst(ireset), .h(h), .v(v),
      .active(active), .hs_act(hs_act), .vs_act(vs_act),
      .frame_start(frame_start), .line_last(line_last), .frame_last(frame_last)
   );

   // The frame's first pixel already uses the freshly sampled enable.
   assign frame_en = frame_start ? ienable : en_latch;
   assign rd_addr  = line_base + ADDR_W'(h[HW-1:1]);

   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         en_latch  <= 1'b0;
         line_base <= '0;
      end else begin
         en_latch <= frame_en;
         if (line_last) begin
            if (frame_last)
               line_base <= '0;
            else if (v[0] && (v < VW'(V_ACTIVE)))
               line_base <= line_base + ADDR_W'(SRC_W);
         end
      end
   end

   // Stage 1: read request; stage 2: read data returns; stage 3: display outputs.
   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         oaddr        <= '0;
         ord_en       <= 1'b0;
         s1           <= '0;
         s2           <= '0;
         rd_en2       <= 1'b0;
         ode          <= 1'b0;
         ohsync       <= ~HS_POL;
         ovsync       <= ~VS_POL;
         oframe_start <= 1'b0;
         opixel       <= '0;
      end else begin
         ord_en <= active && frame_en;
         if (active && frame_en)
            oaddr <= rd_addr;
         s1     <= '{de: active, hs: hs_act, vs: vs_act, fs: frame_start};
         s2     <= s1;
         rd_en2 <= ord_en;
         ode          <= s2.de;
         ohsync       <= s2.hs ? HS_POL : ~HS_POL;
         ovsync       <= s2.vs ? VS_POL : ~VS_POL;
         oframe_start <= s2.fs;
         opixel       <= (s2.de && rd_en2) ? rgb444_to_888(rgb444_t'(irdata)) : 24'h0;
      end
   end

endmodule

// File: tb/tb_frame_reader.sv
// tb/tb_frame_reader.sv - directed self-checking bench for frame_reader
module tb_frame_reader;

   localparam int HA = 16, HF = 2, HS = 4, HB = 2;
   localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int SW = HA / 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ienable = 1'b1;

   logic [16:0] addr, f_addr;
   logic        rd_en, f_rd_en;
   logic [11:0] rdata;
   logic [11:0] f_rdata = 12'h0;
   logic        hsync, vsync, de, fs;
   logic        f_hsync, f_vsync, f_de, f_fs;
   logic [23:0] pixel, f_pixel;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   frame_reader #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SRC_W(SW)
   ) u_dut (
      .iclk(clk), .ireset(rst), .ienable(ienable),
      .oaddr(addr), .ord_en(rd_en), .irdata(rdata),
      .ohsync(hsync), .ovsync(vsync), .ode(de), .opixel(pixel), .oframe_start(fs)
   );

   frame_reader u_full (
      .iclk(clk), .ireset(rst), .ienable(ienable),
      .oaddr(f_addr), .ord_en(f_rd_en), .irdata(f_rdata),
      .ohsync(f_hsync), .ovsync(f_vsync), .ode(f_de), .opixel(f_pixel), .oframe_start(f_fs)
   );

   function automatic logic [11:0] mem_f(input int a);
      return (a == 5) ? 12'hF80 : 12'(a ^ 32'h3C7);
   endfunction

   function automatic logic [23:0] exp888(input logic [11:0] x);
      return {x[11:8], x[11:8], x[7:4], x[7:4], x[3:0], x[3:0]};
   endfunction

   always @(posedge clk)
      if (rd_en) rdata <= mem_f(int'(addr));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_hsync"}, hsync, 1'b1);
      check({tag, "_vsync"}, vsync, 1'b1);
      check({tag, "_de"}, de, 1'b0);
      check({tag, "_pixel"}, pixel, 24'h0);
      check({tag, "_rd_en"}, rd_en, 1'b0);
      check({tag, "_addr"}, addr, 17'h0);
      check({tag, "_fs"}, fs, 1'b0);
      check({tag, "_full_hsync"}, f_hsync, 1'b1);
      check({tag, "_full_rd_en"}, f_rd_en, 1'b0);
   endtask

   // Entered at the negedge of cycle 0 after reset release; reference uses default 640x480 timing.
   task automatic run_full(input int ncyc);
      int p, h, v;
      logic        e_rd, e_de, e_hs, e_fs;
      logic [16:0] e_addr = '0;
      for (int c = 0; c < ncyc; c++) begin
         e_rd = 1'b0;
         if (c >= 1) begin
            p = c - 1; h = p % 800; v = p / 800;
            e_rd = (h < 640) && (v < 480);
            if (e_rd) e_addr = 17'((v / 2) * 320 + h / 2);
         end
         check("full_rd_en", f_rd_en, e_rd);
         check("full_addr", f_addr, e_addr);
         e_de = 1'b0; e_hs = 1'b1; e_fs = 1'b0;
         if (c >= 3) begin
            p = c - 3; h = p % 800; v = p / 800;
            e_de = (h < 640) && (v < 480);
            e_hs = !((h >= 656) && (h < 752));
            e_fs = (p == 0);
         end
         check("full_de", f_de, e_de);
         check("full_hsync", f_hsync, e_hs);
         check("full_vsync", f_vsync, 1'b1);
         check("full_fs", f_fs, e_fs);
         @(negedge clk);
      end
   endtask

   // sched=1: ienable drops on line 3 of frame 0 and returns mid frame 1.
   task automatic run_small(input int ncyc, input bit sched);
      int p, h, v, a;
      bit          fen [0:7];
      logic        e_rd, e_de, e_hs, e_vs, e_fs;
      logic [16:0] e_addr = '0;
      logic [23:0] e_pix;
      for (int c = 0; c < ncyc; c++) begin
         if (sched) ienable = (c < 3 * HT) || (c >= FT + 100);
         if (c % FT == 0) fen[c / FT] = ienable;
         e_rd = 1'b0;
         if (c >= 1) begin
            p = c - 1; h = p % HT; v = (p / HT) % VT;
            e_rd = (h < HA) && (v < VA) && fen[p / FT];
            if (e_rd) e_addr = 17'((v / 2) * SW + h / 2);
         end
         check("rd_en", rd_en, e_rd);
         check("addr", addr, e_addr);
         e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_pix = 24'h0;
         if (c >= 3) begin
            p = c - 3; h = p % HT; v = (p / HT) % VT;
            e_de = (h < HA) && (v < VA);
            e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
            e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
            e_fs = (h == 0) && (v == 0);
            a    = (v / 2) * SW + h / 2;
            if (e_de && fen[p / FT]) e_pix = exp888(mem_f(a));
            if (p < FT && (h == 10 || h == 11) && v < 2)
               check("px5", pixel, 24'hFF8800);
         end
         check("de", de, e_de);
         check("hsync", hsync, e_hs);
         check("vsync", vsync, e_vs);
         check("fs", fs, e_fs);
         check("pixel", pixel, e_pix);
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (10) @(negedge clk);
      check_reset("rst_hold");
      rst = 1'b0;
      run_full(1700);

      rst = 1'b1;
      repeat (10) @(negedge clk);
      check_reset("rst_again");
      rst = 1'b0;
      run_small(3 * FT + 4 * HT + 11, 1'b1);

      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset("rst_async");
      repeat (3) @(negedge clk);
      check_reset("rst_async_hold");
      rst = 1'b0;
      ienable = 1'b1;
      run_small(FT + 40, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
